iterative_multiplier: RTL

Multi-cycle shift-add multiplier, WIDTH×WIDTH -> 2·WIDTH, with signed and unsigned modes and valid/ready handshakes on both sides. It is the sequential, area-reduced successor to the combinational base multiplier in `src/common/`. It is intended for the execute stage's MUL path, where a multi-cycle latency is acceptable in exchange for one adder instead of an array.

---
 rtl/iterative_multiplier_if.sv | 25 ++
 rtl/iterative_multiplier.sv | 121 ++++++++++++
 2 files changed

// File: rtl/iterative_multiplier_if.sv
// Operand/result handshake bundle for the iterative multiplier.
// Carries valid/ready on the operand side and on the result side.
// master = producer/consumer of the block, slave = the multiplier itself.
interface iterative_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/iterative_multiplier.sv
// Shift-add WIDTHxWIDTH -> 2*WIDTH multiplier, signed or unsigned, one adder.
// Latency: out_valid rises WIDTH+1 edges after the accept edge, data-independent.
// Backpressure: result/out_valid held while out_ready=0; in_ready only in IDLE.
module iterative_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  iterative_multiplier_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH:0]   acc_shift;
  logic [2*WIDTH-1:0] prod;
  logic               last;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs, decoded from state only.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand magnitudes and one shift-add step; the upper half carries one
  // extra bit so the add never overflows before the shift.
  always_comb begin
    a_mag     = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag     = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    add_hi    = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
    acc_shift = {add_hi, acc[WIDTH-1:0]} >> 1;
    prod      = acc[2*WIDTH-1:0];
    last      = (cnt == CW'(WIDTH));
  end

  // Datapath: capture on accept, iterate WIDTH times, then apply the sign
  // in a final CALC cycle so the adder is never shared with the negation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (last) begin
            result_q <= neg ? (~prod + (2*WIDTH)'(1)) : prod;
          end else begin
            acc    <= acc_shift;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;

endmodule
